// File: rtl/frame_buf_pkg.sv
// Shared frame buffer definitions: geometry, address width, read-port ids and
// the per-read tag carried through the RAM latency pipeline.
package frame_buf_pkg;

   localparam int H_RES   = 640;
   localparam int V_RES   = 480;
   localparam int AW      = 19;
   localparam int PIX_W   = 8;
   localparam int COORD_W = 10;

   localparam logic PORT_D = 1'b0;
   localparam logic PORT_P = 1'b1;

   typedef enum logic {
      ST_NORMAL = 1'b0,
      ST_FORCE  = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic valid;
      logic id;
      logic oob;
   } rd_tag_t;

   function automatic logic [AW-1:0] lin_addr(input logic [COORD_W-1:0] x,
                                              input logic [COORD_W-1:0] y);
      return AW'(x) + AW'(y) * AW'(H_RES);
   endfunction

   function automatic logic coord_oob(input logic [COORD_W-1:0] x,
                                      input logic [COORD_W-1:0] y);
      return (int'(x) >= H_RES) || (int'(y) >= V_RES);
   endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Fixed-depth shift register that tracks each granted read (valid, port id,
// out-of-range flag) until its data leaves the frame buffer.
module rd_tag_pipe
   import frame_buf_pkg::*;
#(
   parameter int DEPTH = 3,
   parameter int W     = $bits(rd_tag_t)
) (
   input  logic         clk_50,
   input  logic         reset_n,
   input  logic [W-1:0] tag_in,
   output logic [W-1:0] tag_out
);

   logic [W-1:0] stage [DEPTH];

   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      end else begin
         stage[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/frame_buf_rd_arbiter.sv
// Two-port read arbiter for the frame buffer: display (D) has priority, the
// stereo port (P) is force-granted after MAX_WAIT consecutive blocked cycles.
module frame_buf_rd_arbiter
   import frame_buf_pkg::*;
#(
   parameter int RD_LAT   = 2,
   parameter int MAX_WAIT = 16
) (
   input  logic                            clk_50,
   input  logic                            reset_n,
   input  logic                            d_req,
   input  logic [COORD_W-1:0]              d_x,
   input  logic [COORD_W-1:0]              d_y,
   input  logic                            p_req,
   input  logic [COORD_W-1:0]              p_x,
   input  logic [COORD_W-1:0]              p_y,
   output logic                            d_gnt,
   output logic                            p_gnt,
   output logic                            d_rvalid,
   output logic                            p_rvalid,
   output logic [PIX_W-1:0]                d_rdata,
   output logic [PIX_W-1:0]                p_rdata,
   output logic                            p_forced,
   output logic [AW-1:0]                   mem_rd_addr,
   input  logic [PIX_W-1:0]                mem_q,
   output arb_state_e                      dbg_state,
   output logic [$clog2(MAX_WAIT+1)-1:0]   dbg_wait_cnt
);

   localparam int WCW = $clog2(MAX_WAIT + 1);

   // Handshake: a requester raises req with x/y and holds all three stable
   // until it sees gnt; the cycle with req && gnt is the accepted transfer.
   // A new request may follow immediately in the next cycle.

   arb_state_e      state;
   logic [WCW-1:0]  wait_cnt;
   logic [WCW-1:0]  wait_cnt_nxt;
   logic            force_p;
   logic            any_gnt;
   logic [COORD_W-1:0] sel_x;
   logic [COORD_W-1:0] sel_y;
   logic            sel_oob;
   logic [AW-1:0]   sel_addr;
   rd_tag_t         tag_in;
   rd_tag_t         tag_out;

   assign force_p  = (state == ST_FORCE) && p_req;
   assign p_gnt    = p_req && ((state == ST_FORCE) || !d_req);
   assign d_gnt    = d_req && !force_p;
   assign p_forced = force_p;
   assign any_gnt  = d_gnt || p_gnt;

   assign sel_x    = p_gnt ? p_x : d_x;
   assign sel_y    = p_gnt ? p_y : d_y;
   assign sel_oob  = coord_oob(sel_x, sel_y);
   assign sel_addr = lin_addr(sel_x, sel_y);

   always_comb begin
      wait_cnt_nxt = '0;
      if (p_req && !p_gnt) wait_cnt_nxt = wait_cnt + 1'b1;
   end

   // FORCE is entered in the same edge that makes wait_cnt reach MAX_WAIT,
   // so the override lands in the cycle after the MAX_WAIT-th blocked cycle.
   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         state    <= ST_NORMAL;
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_cnt_nxt;
         case (state)
            ST_NORMAL: if (wait_cnt_nxt == WCW'(MAX_WAIT)) state <= ST_FORCE;
            ST_FORCE:  state <= ST_NORMAL;
            default:   state <= ST_NORMAL;
         endcase
      end
   end

   // Out-of-range requests leave the address alone; their data is zeroed on return.
   always_ff @(posedge clk_50 or negedge reset_n) begin
      if (!reset_n) begin
         mem_rd_addr <= '0;
      end else if (any_gnt && !sel_oob) begin
         mem_rd_addr <= sel_addr;
      end
   end

   always_comb begin
      tag_in       = '0;
      tag_in.valid = any_gnt;
      tag_in.id    = p_gnt ? PORT_P : PORT_D;
      tag_in.oob   = any_gnt && sel_oob;
   end

   rd_tag_pipe #(
      .DEPTH (RD_LAT + 1),
      .W     ($bits(rd_tag_t))
   ) u_tag_pipe (
      .clk_50  (clk_50),
      .reset_n (reset_n),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );

   // rvalid comes straight from the last tag register and rdata from the RAM
   // output register, giving a fixed RD_LAT+1 cycle grant-to-response latency.
   assign d_rvalid = tag_out.valid && (tag_out.id == PORT_D);
   assign p_rvalid = tag_out.valid && (tag_out.id == PORT_P);
   assign d_rdata  = (d_rvalid && !tag_out.oob) ? mem_q : '0;
   assign p_rdata  = (p_rvalid && !tag_out.oob) ? mem_q : '0;

   assign dbg_state    = state;
   assign dbg_wait_cnt = wait_cnt;

endmodule

// File: tb/tb_frame_buf_rd_arbiter.sv
// Directed testbench for frame_buf_rd_arbiter with a 2-cycle-latency frame
// buffer model; each scenario task checks its own expected values inline.
module tb_frame_buf_rd_arbiter;
   import frame_buf_pkg::*;

   logic               clk_50;
   logic               reset_n;
   logic               d_req;
   logic [9:0]         d_x;
   logic [9:0]         d_y;
   logic               p_req;
   logic [9:0]         p_x;
   logic [9:0]         p_y;
   logic               d_gnt;
   logic               p_gnt;
   logic               d_rvalid;
   logic               p_rvalid;
   logic [7:0]         d_rdata;
   logic [7:0]         p_rdata;
   logic               p_forced;
   logic [AW-1:0]      mem_rd_addr;
   logic [7:0]         mem_q;
   arb_state_e         dbg_state;
   logic [4:0]         dbg_wait_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] mem [0:H_RES*V_RES-1];
   logic [7:0] ram_s1;

   frame_buf_rd_arbiter #(
      .RD_LAT   (2),
      .MAX_WAIT (16)
   ) dut (
      .clk_50       (clk_50),
      .reset_n      (reset_n),
      .d_req        (d_req),
      .d_x          (d_x),
      .d_y          (d_y),
      .p_req        (p_req),
      .p_x          (p_x),
      .p_y          (p_y),
      .d_gnt        (d_gnt),
      .p_gnt        (p_gnt),
      .d_rvalid     (d_rvalid),
      .p_rvalid     (p_rvalid),
      .d_rdata      (d_rdata),
      .p_rdata      (p_rdata),
      .p_forced     (p_forced),
      .mem_rd_addr  (mem_rd_addr),
      .mem_q        (mem_q),
      .dbg_state    (dbg_state),
      .dbg_wait_cnt (dbg_wait_cnt)
   );

   // clock / reset
   initial clk_50 = 1'b0;
   always #10 clk_50 = ~clk_50;

   // frame buffer model: two register stages of read latency
   always @(posedge clk_50) begin
      ram_s1 <= mem[mem_rd_addr];
      mem_q  <= ram_s1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   function automatic logic [7:0] exp_pix(input logic [9:0] x, input logic [9:0] y);
      if (int'(x) >= H_RES || int'(y) >= V_RES) return 8'h00;
      return mem[int'(x) + int'(y) * H_RES];
   endfunction

   task automatic next_cycle();
      @(posedge clk_50);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk_50);
      @(negedge clk_50);
      n_checks++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_d_rvalid: got %b expected 0", d_rvalid); end
      n_checks++; if (p_rvalid !== 1'b0) begin n_fail++; $display("FAIL reset_p_rvalid: got %b expected 0", p_rvalid); end
      n_checks++; if (p_forced !== 1'b0) begin n_fail++; $display("FAIL reset_p_forced: got %b expected 0", p_forced); end
      n_checks++; if (d_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_d_rdata: got %h expected 00", d_rdata); end
      n_checks++; if (p_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_p_rdata: got %h expected 00", p_rdata); end
      n_checks++; if (mem_rd_addr !== 19'd0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", mem_rd_addr); end
      n_checks++; if (dbg_wait_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_wait_cnt: got %0d expected 0", dbg_wait_cnt); end
      n_checks++; if (dbg_state !== ST_NORMAL) begin n_fail++; $display("FAIL reset_state: got %0d expected NORMAL", dbg_state); end
      reset_n = 1'b1;
      next_cycle();
   endtask

   task automatic test_single_d();
      logic exp_v;
      for (int c = 0; c < 6; c++) begin
         d_req = (c == 0); d_x = 10'd5; d_y = 10'd2; p_req = 1'b0;
         @(negedge clk_50);
         exp_v = (c == 0);
         n_checks++; if (d_gnt !== exp_v) begin n_fail++; $display("FAIL single_d_gnt c%0d: got %b expected %b", c, d_gnt, exp_v); end
         if (c >= 1) begin
            n_checks++; if (mem_rd_addr !== 19'd1285) begin n_fail++; $display("FAIL single_addr c%0d: got %0d expected 1285", c, mem_rd_addr); end
         end
         exp_v = (c == 3);
         n_checks++; if (d_rvalid !== exp_v) begin n_fail++; $display("FAIL single_d_rvalid c%0d: got %b expected %b", c, d_rvalid, exp_v); end
         if (c == 3) begin
            n_checks++; if (d_rdata !== 8'hA7) begin n_fail++; $display("FAIL single_d_rdata: got %h expected a7", d_rdata); end
         end
         n_checks++; if (p_rvalid !== 1'b0) begin n_fail++; $display("FAIL single_p_rvalid c%0d: got %b expected 0", c, p_rvalid); end
         next_cycle();
      end
   endtask

   task automatic test_corner();
      logic       exp_v;
      logic [7:0] exp_d;
      for (int c = 0; c < 7; c++) begin
         p_req = 1'b0;
         case (c)
            0:       begin d_req = 1'b1; d_x = 10'd639; d_y = 10'd479; end
            1:       begin d_req = 1'b1; d_x = 10'd640; d_y = 10'd0;   end
            2:       begin d_req = 1'b1; d_x = 10'd0;   d_y = 10'd480; end
            default: begin d_req = 1'b0; d_x = 10'd0;   d_y = 10'd0;   end
         endcase
         @(negedge clk_50);
         exp_v = (c < 3);
         n_checks++; if (d_gnt !== exp_v) begin n_fail++; $display("FAIL corner_gnt c%0d: got %b expected %b", c, d_gnt, exp_v); end
         if (c >= 1) begin
            n_checks++; if (mem_rd_addr !== 19'd307199) begin n_fail++; $display("FAIL corner_addr c%0d: got %0d expected 307199", c, mem_rd_addr); end
         end
         exp_v = (c >= 3 && c <= 5);
         n_checks++; if (d_rvalid !== exp_v) begin n_fail++; $display("FAIL corner_rvalid c%0d: got %b expected %b", c, d_rvalid, exp_v); end
         if (exp_v) begin
            exp_d = (c == 3) ? 8'h3C : 8'h00;
            n_checks++; if (d_rdata !== exp_d) begin n_fail++; $display("FAIL corner_rdata c%0d: got %h expected %h", c, d_rdata, exp_d); end
         end
         next_cycle();
      end
   endtask

   task automatic test_starvation();
      logic       fp;
      logic       ep;
      logic [4:0] exp_w;
      int         g;
      for (int c = 0; c < 37; c++) begin
         d_req = (c < 34); d_x = 10'd100; d_y = 10'd0;
         p_req = (c < 34); p_x = 10'd200; p_y = 10'd0;
         @(negedge clk_50);
         if (c < 34) begin
            fp    = ((c % 17) == 16);
            exp_w = 5'(c % 17);
            n_checks++; if (p_gnt !== fp) begin n_fail++; $display("FAIL starve_p_gnt c%0d: got %b expected %b", c, p_gnt, fp); end
            n_checks++; if (d_gnt !== !fp) begin n_fail++; $display("FAIL starve_d_gnt c%0d: got %b expected %b", c, d_gnt, !fp); end
            n_checks++; if (p_forced !== fp) begin n_fail++; $display("FAIL starve_forced c%0d: got %b expected %b", c, p_forced, fp); end
            n_checks++; if (dbg_wait_cnt !== exp_w) begin n_fail++; $display("FAIL starve_wait_cnt c%0d: got %0d expected %0d", c, dbg_wait_cnt, exp_w); end
         end
         if (c >= 3) begin
            g  = c - 3;
            ep = ((g % 17) == 16);
            n_checks++; if (p_rvalid !== ep) begin n_fail++; $display("FAIL starve_p_rvalid c%0d: got %b expected %b", c, p_rvalid, ep); end
            n_checks++; if (d_rvalid !== !ep) begin n_fail++; $display("FAIL starve_d_rvalid c%0d: got %b expected %b", c, d_rvalid, !ep); end
            if (ep) begin
               n_checks++; if (p_rdata !== exp_pix(10'd200, 10'd0)) begin n_fail++; $display("FAIL starve_p_rdata c%0d: got %h expected %h", c, p_rdata, exp_pix(10'd200, 10'd0)); end
            end else begin
               n_checks++; if (d_rdata !== exp_pix(10'd100, 10'd0)) begin n_fail++; $display("FAIL starve_d_rdata c%0d: got %h expected %h", c, d_rdata, exp_pix(10'd100, 10'd0)); end
            end
         end
         next_cycle();
      end
      d_req = 1'b0; p_req = 1'b0;
      @(negedge clk_50);
      n_checks++; if (dbg_state !== ST_NORMAL) begin n_fail++; $display("FAIL starve_end_state: got %0d expected NORMAL", dbg_state); end
      n_checks++; if (d_rvalid !== 1'b0 || p_rvalid !== 1'b0) begin n_fail++; $display("FAIL starve_drain: got d=%b p=%b expected 0 0", d_rvalid, p_rvalid); end
      next_cycle();
   endtask

   task automatic test_interleave();
      logic       ed;
      logic       ep;
      logic [7:0] exp_d;
      int         g;
      for (int c = 0; c < 8; c++) begin
         d_req = (c == 0 || c == 2); d_x = 10'(c + 1); d_y = 10'(c);
         p_req = (c == 1 || c == 3); p_x = 10'(c + 1); p_y = 10'(c);
         @(negedge clk_50);
         ed = (c == 0 || c == 2);
         ep = (c == 1 || c == 3);
         n_checks++; if (d_gnt !== ed) begin n_fail++; $display("FAIL inter_d_gnt c%0d: got %b expected %b", c, d_gnt, ed); end
         n_checks++; if (p_gnt !== ep) begin n_fail++; $display("FAIL inter_p_gnt c%0d: got %b expected %b", c, p_gnt, ep); end
         g  = c - 3;
         ed = (g == 0 || g == 2);
         ep = (g == 1 || g == 3);
         exp_d = exp_pix(10'(g + 1), 10'(g));
         n_checks++; if (d_rvalid !== ed) begin n_fail++; $display("FAIL inter_d_rvalid c%0d: got %b expected %b", c, d_rvalid, ed); end
         n_checks++; if (p_rvalid !== ep) begin n_fail++; $display("FAIL inter_p_rvalid c%0d: got %b expected %b", c, p_rvalid, ep); end
         if (ed) begin
            n_checks++; if (d_rdata !== exp_d) begin n_fail++; $display("FAIL inter_d_rdata c%0d: got %h expected %h", c, d_rdata, exp_d); end
         end
         if (ep) begin
            n_checks++; if (p_rdata !== exp_d) begin n_fail++; $display("FAIL inter_p_rdata c%0d: got %h expected %h", c, p_rdata, exp_d); end
         end
         next_cycle();
      end
   endtask

   task automatic test_reset_mid();
      logic ed;
      d_req = 1'b1; d_x = 10'd10; d_y = 10'd1; p_req = 1'b0;
      next_cycle();
      d_req = 1'b0; p_req = 1'b1; p_x = 10'd20; p_y = 10'd1;
      next_cycle();
      p_req = 1'b0;
      n_checks++; if (mem_rd_addr !== 19'd660) begin n_fail++; $display("FAIL rstmid_addr_before: got %0d expected 660", mem_rd_addr); end
      #4;
      reset_n = 1'b0;
      #1;
      n_checks++; if (mem_rd_addr !== 19'd0) begin n_fail++; $display("FAIL rstmid_addr: got %0d expected 0", mem_rd_addr); end
      n_checks++; if (d_rvalid !== 1'b0 || p_rvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_rvalid: got d=%b p=%b expected 0 0", d_rvalid, p_rvalid); end
      n_checks++; if (d_rdata !== 8'h00 || p_rdata !== 8'h00) begin n_fail++; $display("FAIL rstmid_rdata: got d=%h p=%h expected 00 00", d_rdata, p_rdata); end
      n_checks++; if (p_forced !== 1'b0) begin n_fail++; $display("FAIL rstmid_forced: got %b expected 0", p_forced); end
      @(posedge clk_50);
      @(negedge clk_50);
      reset_n = 1'b1;
      next_cycle();
      for (int c = 0; c < 9; c++) begin
         d_req = (c == 5); d_x = 10'd7; d_y = 10'd3;
         @(negedge clk_50);
         if (c == 5) begin
            n_checks++; if (d_gnt !== 1'b1) begin n_fail++; $display("FAIL rstmid_new_gnt: got %b expected 1", d_gnt); end
         end
         ed = (c == 8);
         n_checks++; if (d_rvalid !== ed) begin n_fail++; $display("FAIL rstmid_d_rvalid c%0d: got %b expected %b", c, d_rvalid, ed); end
         n_checks++; if (p_rvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_p_rvalid c%0d: got %b expected 0", c, p_rvalid); end
         if (ed) begin
            n_checks++; if (d_rdata !== exp_pix(10'd7, 10'd3)) begin n_fail++; $display("FAIL rstmid_rdata: got %h expected %h", d_rdata, exp_pix(10'd7, 10'd3)); end
         end
         next_cycle();
      end
   endtask

   task automatic test_p_sweep();
      int         a;
      logic [7:0] exp_d;
      for (int c = 0; c < 104; c++) begin
         a     = 1000 + c;
         d_req = 1'b0;
         p_req = (c < 100); p_x = 10'(a % H_RES); p_y = 10'(a / H_RES);
         @(negedge clk_50);
         if (c < 100) begin
            n_checks++; if (p_gnt !== 1'b1) begin n_fail++; $display("FAIL sweep_p_gnt c%0d: got %b expected 1", c, p_gnt); end
         end
         n_checks++; if (dbg_wait_cnt !== 5'd0) begin n_fail++; $display("FAIL sweep_wait_cnt c%0d: got %0d expected 0", c, dbg_wait_cnt); end
         if (c >= 3 && c < 103) begin
            exp_d = mem[1000 + c - 3];
            n_checks++; if (p_rvalid !== 1'b1) begin n_fail++; $display("FAIL sweep_p_rvalid c%0d: got %b expected 1", c, p_rvalid); end
            n_checks++; if (p_rdata !== exp_d) begin n_fail++; $display("FAIL sweep_p_rdata c%0d: got %h expected %h", c, p_rdata, exp_d); end
         end else begin
            n_checks++; if (p_rvalid !== 1'b0) begin n_fail++; $display("FAIL sweep_p_idle c%0d: got %b expected 0", c, p_rvalid); end
         end
         n_checks++; if (d_rvalid !== 1'b0) begin n_fail++; $display("FAIL sweep_d_rvalid c%0d: got %b expected 0", c, d_rvalid); end
         next_cycle();
      end
   endtask

   initial begin
      reset_n = 1'b0;
      d_req = 1'b0; d_x = '0; d_y = '0;
      p_req = 1'b0; p_x = '0; p_y = '0;
      for (int a = 0; a < H_RES * V_RES; a++) mem[a] = 8'((a * 37 + 11) ^ (a >> 7));
      mem[1285]   = 8'hA7;
      mem[307199] = 8'h3C;

      test_reset();
      test_single_d();
      test_corner();
      test_starvation();
      test_interleave();
      test_reset_mid();
      test_p_sweep();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/frame_buf_rd_arbiter.md
# frame_buf_rd_arbiter

Shares the single synchronous read port of the 640x480 8-bit frame buffer between two requesters: display scanout (port D, priority) and stereo processing (port P). Each requester presents pixel coordinates. The arbiter grants one request per cycle, converts coordinates to a linear address, tracks each read through the RAM pipeline, and returns data to the requester that issued it. The block sits between the read side of the frame buffer and its consumers, in the frame buffer's read clock domain.

## Interface
- H_RES, 640, pixels per line
- V_RES, 480, lines per frame
- AW, 19, linear address width; must be ≥ clog2(H_RES*V_RES)
- RD_LAT, 2, RAM read latency: mem_q reflects mem_rd_addr presented RD_LAT cycles earlier
- MAX_WAIT, 16, consecutive blocked cycles of P before P is force-granted; ≥1
- clk_50  in  1  sole clock; frame buffer read clock
- reset_n  in  1  asynchronous, active-low reset
- d_req / p_req  in  1  read request, level, per port
- d_x, d_y / p_x, p_y  in  10  pixel column and row
- d_gnt / p_gnt  out  1  request accepted this cycle (combinational from req and state)
- d_rvalid / p_rvalid  out  1  one-cycle pulse; rdata valid
- d_rdata / p_rdata  out  8  returned pixel
- p_forced  out  1  pulse; this cycle's P grant was a starvation override
- mem_rd_addr  out  AW  registered read address to the frame buffer
- mem_q  in  8  frame buffer read data

## Operation
- Requesters hold req, x and y stable until gnt. A request is accepted in any cycle with req && gnt. A requester may issue back-to-back requests.
- Arbitration states:
  - NORMAL: D wins when d_req. P is granted only when !d_req.
  - FORCE: P wins if p_req. After that grant, or if p_req drops, return to NORMAL.
- Starvation counter wait_cnt (clog2(MAX_WAIT+1) bits):
  - Increments each cycle with p_req && !p_gnt.
  - Clears on p_gnt or !p_req.
  - When wait_cnt == MAX_WAIT, the next cycle enters FORCE.
  - A forced P grant blocks D for that cycle (d_gnt=0); the display side tolerates this.
- Address: addr = x + y*H_RES, computed at AW bits with no truncation for in-range inputs. mem_rd_addr is registered on grant.
- Out of range (x ≥ H_RES or y ≥ V_RES):
  - The request is still granted.
  - mem_rd_addr keeps its previous value.
  - The response has rdata = 0x00 at normal latency.
- Tag pipeline: {valid, port id, oob} shifts RD_LAT+1 stages, one per cycle. At the final stage it steers mem_q (or 0x00 if oob) to the tagged port's rdata and pulses that port's rvalid.
- Responses on each port return in issue order. Responses from both ports never coincide in the same cycle.
- With no grant, mem_rd_addr holds its value and no tag is inserted.

## Timing
- Grant in cycle N. mem_rd_addr is updated at the end of N. mem_q is valid in N+1+RD_LAT. rvalid/rdata are registered, so with RD_LAT=2 the response appears in cycle N+3 (fixed latency RD_LAT+1).
- Throughput: one grant per cycle in total across both ports.
- Reset values: d_rvalid=p_rvalid=p_forced=0, rdata=0x00, mem_rd_addr=0, wait_cnt=0, state NORMAL, tag pipeline cleared.
- Reset mid-operation: in-flight reads are discarded. No rvalid appears for requests granted before reset. The first grant after reset_n rises can occur in the first clk_50 cycle.
- Simultaneous d_req and p_req with wait_cnt == MAX_WAIT-1: D is granted this cycle, wait_cnt reaches MAX_WAIT, and P is forced next cycle.

## Structure
- Shared package `frame_buf_pkg`: H_RES, V_RES, AW, and the port-id encoding (PORT_D=0, PORT_P=1). Used by frame buffer instantiations and consumers.
- Sub-module `rd_tag_pipe`: parameterised depth RD_LAT+1, width 3 (valid, id, oob), async active-low clear.
- The top level holds the arbitration FSM, the wait counter, address arithmetic and the response mux.

## Test plan
- Single D read at (x=5, y=2) with RAM preloaded mem[1285]=0xA7 -> d_gnt in cycle N; mem_rd_addr=1285; d_rvalid with d_rdata=0xA7 in N+3; p_rvalid stays 0.
- Corner address (x=639, y=479) -> mem_rd_addr=307199; correct data returned. Request (x=640, y=0) -> granted, mem_rd_addr unchanged, d_rdata=0x00 at N+3.
- d_req and p_req held high continuously, MAX_WAIT=16 -> D granted 16 consecutive cycles, then one p_gnt with p_forced=1 and d_gnt=0, then D resumes; pattern repeats every 17 cycles.
- Interleaved grants D, P, D, P on consecutive cycles -> four responses in consecutive cycles N+3..N+6, each on the correct port, in order, with the correct data.
- reset_n pulled low one cycle after two grants -> all outputs 0 asynchronously; no rvalid after release; a new grant after release returns data at normal latency.
- P alone, back-to-back for 100 cycles over a linear address sweep -> 100 p_rvalid pulses with data matching the RAM model; wait_cnt never nonzero.
